// File: rtl/branch_resolve_ctrl.sv
// Control-hazard sequencer for the pipelined SCPU datapath.
// Detects control transfers in ID, freezes fetch and bubbles ID until EX
// resolves, then issues exactly one PC redirect (target or fall-through).
// A wait timeout forces a fall-through redirect and raises a sticky flag.
module branch_resolve_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [31:0]      id_inst,
   input  logic [31:0]      id_pc,
   input  logic             mem_stall,
   input  logic             ex_resolve_valid,
   input  logic             ex_taken,
   input  logic [31:0]      ex_target,
   output logic             pc_we,
   output logic             if_id_flush,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             busy,
   output logic             timeout_err,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] taken_count
);

   localparam int unsigned WC_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WC_W-1:0] WC_LIMIT = WC_W'(TIMEOUT);

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic {
      IDLE    = 1'b0,
      WAIT_EX = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [31:0]     fallthrough_pc;
   logic [WC_W-1:0] wait_cnt;

   logic            is_cti;
   logic            detect;
   logic            resolve;
   logic            force_to;
   logic            waiting;

   // Instruction bits above the opcode are not needed for classification.
   logic            unused_inst_bits;
   assign unused_inst_bits = ^id_inst[31:7];

   // Control-transfer classification of the ID-stage instruction.
   always_comb begin
      is_cti = 1'b0;
      if (id_valid) begin
         case (id_inst[6:0])
            OP_BRANCH, OP_JAL, OP_JALR: is_cti = 1'b1;
            default:                    is_cti = 1'b0;
         endcase
      end
   end

   // Qualified events; mem_stall freezes everything.
   always_comb begin
      detect   = 1'b0;
      resolve  = 1'b0;
      force_to = 1'b0;
      waiting  = 1'b0;
      if (!mem_stall) begin
         if (state == IDLE) begin
            detect = is_cti;
         end else begin
            resolve  = ex_resolve_valid;
            force_to = !ex_resolve_valid && (wait_cnt == WC_LIMIT);
            waiting  = !ex_resolve_valid && (wait_cnt != WC_LIMIT);
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (detect) begin
               state_nxt = WAIT_EX;
            end
         end
         WAIT_EX: begin
            if (resolve || force_to) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Mealy outputs from state and current inputs.
   always_comb begin
      pc_we          = 1'b1;
      if_id_flush    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      busy           = (state == WAIT_EX);
      if (mem_stall) begin
         pc_we = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (is_cti) begin
                  pc_we       = 1'b0;
                  if_id_flush = 1'b1;
               end
            end
            WAIT_EX: begin
               if_id_flush = 1'b1;
               pc_we       = 1'b0;
               if (resolve) begin
                  pc_we          = 1'b1;
                  redirect_valid = 1'b1;
                  redirect_pc    = ex_taken ? ex_target : fallthrough_pc;
               end else if (force_to) begin
                  pc_we          = 1'b1;
                  redirect_valid = 1'b1;
                  redirect_pc    = fallthrough_pc;
               end
            end
            default: begin
               pc_we = 1'b1;
            end
         endcase
      end
   end

   // Fall-through latch, wait counter, sticky timeout flag, statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         fallthrough_pc <= 32'd0;
         wait_cnt       <= '0;
         timeout_err    <= 1'b0;
         br_count       <= '0;
         taken_count    <= '0;
      end else begin
         if (detect) begin
            fallthrough_pc <= id_pc + 32'd4;
            wait_cnt       <= '0;
            if (br_count != {CNT_W{1'b1}}) begin
               br_count <= br_count + CNT_W'(1);
            end
         end
         if (waiting) begin
            wait_cnt <= wait_cnt + WC_W'(1);
         end
         if (resolve && ex_taken && (taken_count != {CNT_W{1'b1}})) begin
            taken_count <= taken_count + CNT_W'(1);
         end
         if (force_to) begin
            timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: two instances (default parameters and
// TIMEOUT=4/CNT_W=2) share one directed stimulus stream. A transaction-level
// model predicts every output each cycle; literal checks pin key points.
module tb_branch_resolve_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 1'b0;
   logic [31:0] id_inst = 32'd0;
   logic [31:0] id_pc = 32'd0;
   logic        mem_stall = 1'b0;
   logic        ex_resolve_valid = 1'b0;
   logic        ex_taken = 1'b0;
   logic [31:0] ex_target = 32'd0;

   logic        pc_we_a, flush_a, rv_a, busy_a, terr_a;
   logic [31:0] rpc_a;
   logic [15:0] br_a, tk_a;
   logic        pc_we_b, flush_b, rv_b, busy_b, terr_b;
   logic [31:0] rpc_b;
   logic [1:0]  br_b, tk_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   branch_resolve_ctrl dut_a (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
      .mem_stall(mem_stall), .ex_resolve_valid(ex_resolve_valid), .ex_taken(ex_taken),
      .ex_target(ex_target), .pc_we(pc_we_a), .if_id_flush(flush_a),
      .redirect_valid(rv_a), .redirect_pc(rpc_a), .busy(busy_a),
      .timeout_err(terr_a), .br_count(br_a), .taken_count(tk_a)
   );

   branch_resolve_ctrl #(.TIMEOUT(4), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
      .mem_stall(mem_stall), .ex_resolve_valid(ex_resolve_valid), .ex_taken(ex_taken),
      .ex_target(ex_target), .pc_we(pc_we_b), .if_id_flush(flush_b),
      .redirect_valid(rv_b), .redirect_pc(rpc_b), .busy(busy_b),
      .timeout_err(terr_b), .br_count(br_b), .taken_count(tk_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at t=%0t: got=0x%0h expected=0x%0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   localparam int TMO[2]  = '{16, 4};
   localparam int CMAX[2] = '{65535, 3};

   bit          m_pend[2];
   int          m_waited[2];
   logic [31:0] m_fall[2];
   bit          m_terr[2];
   int          m_br[2];
   int          m_tk[2];
   bit          started = 1'b0;

   // Per-cycle prediction and comparison for both instances.
   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            m_pend[k] = 0; m_waited[k] = 0; m_fall[k] = 32'd0;
            m_terr[k] = 0; m_br[k] = 0; m_tk[k] = 0;
         end
         started = 1'b1;
      end else if (started) begin
         for (int k = 0; k < 2; k++) begin
            bit          cti, e_we, e_fl, e_rv;
            logic [31:0] e_rpc;
            string       p;
            p = (k == 0) ? "a." : "b.";
            cti = id_valid && (id_inst[6:0] == 7'h63 || id_inst[6:0] == 7'h6F
                               || id_inst[6:0] == 7'h67);
            e_we = 1; e_fl = 0; e_rv = 0; e_rpc = 32'd0;
            if (mem_stall) begin
               e_we = 0;
            end else if (!m_pend[k]) begin
               if (cti) begin
                  e_we = 0; e_fl = 1;
               end
            end else begin
               e_fl = 1; e_we = 0;
               if (ex_resolve_valid) begin
                  e_we = 1; e_rv = 1; e_rpc = ex_taken ? ex_target : m_fall[k];
               end else if (m_waited[k] == TMO[k]) begin
                  e_we = 1; e_rv = 1; e_rpc = m_fall[k];
               end
            end
            chk({p, "pc_we"},          (k == 0) ? 32'(pc_we_a) : 32'(pc_we_b), 32'(e_we));
            chk({p, "if_id_flush"},    (k == 0) ? 32'(flush_a) : 32'(flush_b), 32'(e_fl));
            chk({p, "redirect_valid"}, (k == 0) ? 32'(rv_a)    : 32'(rv_b),    32'(e_rv));
            chk({p, "redirect_pc"},    (k == 0) ? rpc_a        : rpc_b,        e_rpc);
            chk({p, "busy"},           (k == 0) ? 32'(busy_a)  : 32'(busy_b),  32'(m_pend[k]));
            chk({p, "timeout_err"},    (k == 0) ? 32'(terr_a)  : 32'(terr_b),  32'(m_terr[k]));
            chk({p, "br_count"},       (k == 0) ? 32'(br_a)    : 32'(br_b),    32'(m_br[k]));
            chk({p, "taken_count"},    (k == 0) ? 32'(tk_a)    : 32'(tk_b),    32'(m_tk[k]));
            // advance model to the next cycle
            if (!mem_stall) begin
               if (!m_pend[k]) begin
                  if (cti) begin
                     m_pend[k] = 1; m_waited[k] = 0; m_fall[k] = id_pc + 32'd4;
                     if (m_br[k] < CMAX[k]) m_br[k]++;
                  end
               end else if (ex_resolve_valid) begin
                  m_pend[k] = 0;
                  if (ex_taken && m_tk[k] < CMAX[k]) m_tk[k]++;
               end else if (m_waited[k] == TMO[k]) begin
                  m_pend[k] = 0; m_terr[k] = 1;
               end else begin
                  m_waited[k]++;
               end
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] BEQ  = 32'h0000_0063;
   localparam logic [31:0] BNE  = 32'h0000_1063;
   localparam logic [31:0] JAL  = 32'h0000_006F;
   localparam logic [31:0] JALR = 32'h0000_0067;

   // Apply one cycle of inputs after the edge, return at the mid-cycle sample point.
   task automatic drive(input logic r, input logic v, input logic [31:0] inst,
                        input logic [31:0] pc, input logic st, input logic res,
                        input logic tk, input logic [31:0] tgt);
      @(posedge clk);
      #1;
      rst = r; id_valid = v; id_inst = inst; id_pc = pc;
      mem_stall = st; ex_resolve_valid = res; ex_taken = tk; ex_target = tgt;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(0, 0, NOP, 32'd0, 0, 0, 0, 32'd0);
   endtask

   initial begin
      drive(1, 0, NOP, 32'd0, 0, 0, 0, 32'd0);
      drive(1, 0, NOP, 32'd0, 0, 0, 0, 32'd0);
      idle();
      chk("rst.pc_we", 32'(pc_we_a), 32'd1);
      chk("rst.flush", 32'(flush_a), 32'd0);
      chk("rst.rv", 32'(rv_a), 32'd0);
      chk("rst.rpc", rpc_a, 32'd0);
      chk("rst.busy", 32'(busy_a), 32'd0);
      chk("rst.terr", 32'(terr_a), 32'd0);
      chk("rst.br", 32'(br_a), 32'd0);
      chk("rst.tk", 32'(tk_a), 32'd0);

      // non-CTI stream
      for (int i = 0; i < 10; i++) drive(0, 1, NOP, 32'h40 + 32'(i * 4), 0, 0, 0, 32'd0);
      chk("nop.br", 32'(br_a), 32'd0);
      chk("nop.pc_we", 32'(pc_we_a), 32'd1);
      chk("nop.rv", 32'(rv_a), 32'd0);

      // beq taken, resolved the cycle after detect
      drive(0, 1, BEQ, 32'h100, 0, 0, 0, 32'd0);
      chk("beq.c0.pc_we", 32'(pc_we_a), 32'd0);
      chk("beq.c0.flush", 32'(flush_a), 32'd1);
      drive(0, 0, NOP, 32'd0, 0, 1, 1, 32'h80);
      chk("beq.c1.rv", 32'(rv_a), 32'd1);
      chk("beq.c1.rpc", rpc_a, 32'h80);
      chk("beq.c1.pc_we", 32'(pc_we_a), 32'd1);
      idle();
      chk("beq.br", 32'(br_a), 32'd1);
      chk("beq.tk", 32'(tk_a), 32'd1);
      chk("beq.busy", 32'(busy_a), 32'd0);

      // bne not taken after 3 wait cycles; stray CTI in ID while waiting
      drive(0, 1, BNE, 32'h200, 0, 0, 0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) drive(0, 1, BEQ, 32'h900, 0, 0, 0, 32'd0);
         else        drive(0, 0, NOP, 32'd0, 0, 0, 0, 32'd0);
         chk("bne.wait.busy", 32'(busy_a), 32'd1);
      end
      drive(0, 0, NOP, 32'd0, 0, 1, 0, 32'hDEAD_0000);
      chk("bne.rv", 32'(rv_a), 32'd1);
      chk("bne.rpc", rpc_a, 32'h204);
      idle();
      chk("bne.tk", 32'(tk_a), 32'd1);
      chk("bne.br", 32'(br_a), 32'd2);

      // jal with mem_stall held over a pending resolve
      drive(0, 1, JAL, 32'h400, 0, 0, 0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, NOP, 32'd0, 1, 1, 1, 32'h1000);
         chk("jal.stall.rv", 32'(rv_a), 32'd0);
      end
      drive(0, 0, NOP, 32'd0, 0, 1, 1, 32'h1000);
      chk("jal.rv", 32'(rv_a), 32'd1);
      chk("jal.rpc", rpc_a, 32'h1000);
      chk("jal.b.rv", 32'(rv_b), 32'd1);

      // beq never resolved: timeout in both instances
      drive(0, 1, BEQ, 32'h300, 0, 0, 0, 32'd0);
      for (int i = 1; i <= 17; i++) begin
         idle();
         if (i == 4)  chk("to.b.c4.rv", 32'(rv_b), 32'd0);
         if (i == 5)  begin
            chk("to.b.c5.rv", 32'(rv_b), 32'd1);
            chk("to.b.c5.rpc", rpc_b, 32'h304);
         end
         if (i == 16) chk("to.a.c16.rv", 32'(rv_a), 32'd0);
         if (i == 17) begin
            chk("to.a.c17.rv", 32'(rv_a), 32'd1);
            chk("to.a.c17.rpc", rpc_a, 32'h304);
         end
      end
      idle();
      idle();
      chk("to.a.terr", 32'(terr_a), 32'd1);
      chk("to.b.terr", 32'(terr_b), 32'd1);

      // five taken jalr resolutions: saturation in the narrow instance
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, JALR, 32'h500 + 32'(i * 8), 0, 0, 0, 32'd0);
         drive(0, 0, NOP, 32'd0, 0, 1, 1, 32'h600);
      end
      idle();
      chk("sat.b.br", 32'(br_b), 32'd3);
      chk("sat.b.tk", 32'(tk_b), 32'd3);
      chk("sat.a.br", 32'(br_a), 32'd9);
      chk("sat.a.tk", 32'(tk_a), 32'd7);

      // reset while waiting; late resolve in IDLE is ignored
      drive(0, 1, JALR, 32'h700, 0, 0, 0, 32'd0);
      drive(1, 0, NOP, 32'd0, 0, 0, 0, 32'd0);
      drive(0, 0, NOP, 32'd0, 0, 1, 1, 32'h800);
      chk("rstw.busy", 32'(busy_a), 32'd0);
      chk("rstw.pc_we", 32'(pc_we_a), 32'd1);
      chk("rstw.rv", 32'(rv_a), 32'd0);
      chk("rstw.br", 32'(br_a), 32'd0);
      chk("rstw.tk", 32'(tk_a), 32'd0);
      chk("rstw.terr", 32'(terr_a), 32'd0);
      chk("rstw.b.br", 32'(br_b), 32'd0);
      idle();
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
